adc_capture_multi: RTL and testbench
====================================

Name: adc_capture_multi

Overview:
- Parametrised successor to the fixed 8-bit/512-deep/2-channel sampler-plus-RAM arrangement.
- Drives the parallel ADC handshake (channel select, convst, EOC, cs/rd) and round-robins over NCH channels.
- Stores each sample in an internal per-channel buffer of DEPTH words.
- Adds continuous (wrap-around) capture, an EOC timeout with error flag, and a registered read-back port for downstream processing (beamforming/UART dump).

Parameters:
- NCH, 4, channels sampled per frame; 1..8. ADC channel select is chnl = channel index.
- DW, 8, ADC data width.
- DEPTH, 512, samples stored per channel; power of two.
- AW, $clog2(DEPTH), buffer address width.
- CHW, (NCH>1 ? $clog2(NCH) : 1), read-channel select width.
- EOC_TIMEOUT, 255, max cycles waiting for n_eoc before abort of that conversion.
- PULSE, 2, cycles n_convst and n_rd are held low.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- chnl, out, 3: ADC channel select.
- n_convst, out, 1: start conversion, active low.
- n_eoc, in, 1: end of conversion, active low.
- n_cs, out, 1: ADC chip select, active low.
- n_rd, out, 1: ADC read strobe, active low.
- adc_in, in, DW: ADC data bus.
- start, in, 1: rising-edge-detected capture request.
- continuous, in, 1: 1 = wrap and keep capturing; 0 = stop after DEPTH frames.
- busy, out, 1: capture in progress.
- done, out, 1: high from single-shot completion until the next accepted start.
- timeout_err, out, 1: sticky; set on any EOC timeout; cleared on accepted start.
- wr_frame, out, AW: address of the most recently completed frame.
- rd_ch, in, CHW: read channel.
- rd_addr, in, AW: read address.
- rd_data, out, DW: buffer[rd_ch][rd_addr], 1-cycle latency.

Behaviour:
- Reset values: chnl=0, n_convst=1, n_cs=1, n_rd=1, busy=0, done=0, timeout_err=0, wr_frame=0, rd_data=0.
- Reset has the same effect mid-capture: FSM to IDLE, frame/channel counters to 0. Buffer contents are not cleared.
- start is edge-detected (registered copy). It is accepted only in IDLE. start while busy is ignored.
- IDLE: on accepted start, set ch=0, addr=0, busy=1, done=0, timeout_err=0, then go to SEL.
- SEL (1 cycle): chnl<=ch (setup before convst); go to CONV.
- CONV: n_convst=0 for PULSE cycles; go to WAIT.
- WAIT: count cycles.
  - n_eoc==0 -> READ.
  - Count reaches EOC_TIMEOUT -> set timeout_err, store sample value 0, go to NEXT.
- READ: n_cs=0 and n_rd=0 for PULSE cycles. adc_in is captured on the last low cycle. Then n_cs=n_rd=1 and go to STORE.
- STORE (1 cycle): write buffer[ch][addr] <= sample.
- NEXT:
  - ch<NCH-1: ch++ and go to SEL.
  - ch==NCH-1: ch=0 and wr_frame<=addr.
    - addr<DEPTH-1: addr++ and go to SEL.
    - addr==DEPTH-1, continuous=1: addr wraps to 0 and capture continues.
    - addr==DEPTH-1, continuous=0: busy=0, done=1, go to IDLE.
- Dropping continuous mid-run stops at the next DEPTH-1 frame boundary; it does not stop immediately.
- Per-sample cycle count with no wait = 1 + PULSE + 1(min EOC) + PULSE + 1 + 1.
- Read port is always usable. Read and write to the same location in the same cycle returns old data.

Optional Feature:
- Macro ADC_TRIG_EN.
- Defined:
  - Extra port trig_level (in, DW).
  - After start, the FSM loops converting channel 0 without storing (state ARM).
  - Storage begins with the frame following the first sample where the previous ch0 sample < trig_level and the current one >= trig_level.
  - busy=1 while armed. EOC timeout in ARM sets timeout_err and keeps arming.
- Undefined: storage begins immediately after start; no trig_level port.

Test Plan:
- Reset -> n_convst=n_cs=n_rd=1, busy=0, done=0, chnl=0; assert reset mid-WAIT -> all strobes high the next cycle.
- NCH=4, DEPTH=8, ADC model returns 8'h10*ch+addr, continuous=0, start -> 32 conversions with chnl sequence 0,1,2,3 repeated; done=1; read ch2/addr5 -> 8'h25 one cycle after address applied.
- continuous=1, DEPTH=8 -> after 8 frames addr wraps and buffer[0][0] is overwritten with the 9th-frame value; wr_frame goes 7 then 0; drop continuous -> done at the next frame 7.
- ADC model withholds n_eoc on ch1/frame3 -> timeout_err=1 after 255 cycles, buffer[1][3]=0, capture continues; the next start clears timeout_err.
- start pulsed while busy -> ignored, sample sequence unchanged; start held high -> only one capture.
- ADC_TRIG_EN, trig_level=8'h80, ch0 ramp 0x70,0x78,0x80 -> nothing stored until the 0x80 sample; the first stored frame is the following one.

Source files
------------

// File: rtl/adc_capture_multi_if.sv
// ADC parallel handshake bundle: channel select, convert start, end of
// conversion, chip select, read strobe and data bus.
interface adc_capture_multi_if #(
    parameter int unsigned DW = 8
);
    logic [2:0]    chnl;
    logic          n_convst;
    logic          n_eoc;
    logic          n_cs;
    logic          n_rd;
    logic [DW-1:0] adc_in;

    // Sampler side drives the strobes, the converter answers with EOC and data.
    modport master (output chnl, n_convst, n_cs, n_rd, input n_eoc, adc_in);
    modport slave  (input chnl, n_convst, n_cs, n_rd, output n_eoc, adc_in);
endinterface

// File: rtl/adc_capture_multi.sv
// Multi-channel parallel-ADC sampler with per-channel capture buffers,
// single-shot or wrap-around capture, EOC timeout and registered read-back.
// Optional trigger arming on channel 0 is enabled by defining ADC_TRIG_EN.
module adc_capture_multi #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned DW          = 8,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned AW          = $clog2(DEPTH),
    parameter int unsigned CHW         = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int unsigned EOC_TIMEOUT = 255,
    parameter int unsigned PULSE       = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    adc_capture_multi_if.master  adc,
    input  logic                 start_i,
    input  logic                 continuous_i,
`ifdef ADC_TRIG_EN
    input  logic [DW-1:0]        trig_level_i,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_err_o,
    output logic [AW-1:0]        wr_frame_o,
    input  logic [CHW-1:0]       rd_ch_i,
    input  logic [AW-1:0]        rd_addr_i,
    output logic [DW-1:0]        rd_data_o
);

    localparam int unsigned WCW = (EOC_TIMEOUT > 1) ? $clog2(EOC_TIMEOUT + 1) : 1;
    localparam int unsigned PW  = (PULSE > 1) ? $clog2(PULSE) : 1;

    localparam logic [CHW-1:0] LAST_CH   = CHW'(NCH - 1);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [WCW-1:0] WLAST     = WCW'(EOC_TIMEOUT - 1);
    localparam logic [PW-1:0]  PLAST     = PW'(PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_CONV,
        S_WAIT,
        S_READ,
        S_STORE,
        S_NEXT,
        S_ARM
    } state_t;

    state_t         state_q;
    logic [CHW-1:0] ch_q;
    logic [AW-1:0]  addr_q;
    logic [PW-1:0]  pcnt_q;
    logic [WCW-1:0] wcnt_q;
    logic [DW-1:0]  sample_q;
    logic           start_q;
    logic [2:0]     chnl_q;
    logic           n_convst_q;
    logic           n_cs_q;
    logic           n_rd_q;
    logic           busy_q;
    logic           done_q;
    logic           terr_q;
    logic [AW-1:0]  wr_frame_q;
    logic [DW-1:0]  rd_data_q;

    logic [DW-1:0]  mem [NCH*DEPTH];

    logic           start_rise;
    logic           arming;
    logic           eoc_expired;
    logic           mem_we;
    logic [DW-1:0]  mem_wd;

`ifdef ADC_TRIG_EN
    logic           armed_q;
    logic           have_prev_q;
    logic [DW-1:0]  prev_q;

    assign arming = armed_q;
`else
    assign arming = 1'b0;
`endif

    assign start_rise = start_i & ~start_q;

    // Timeout hit this cycle; while arming nothing is written.
    always_comb begin
        eoc_expired = 1'b0;
        if (state_q == S_WAIT && adc.n_eoc && wcnt_q == WLAST) begin
            eoc_expired = 1'b1;
        end
        mem_we = ((state_q == S_STORE) || eoc_expired) && !arming;
        mem_wd = (state_q == S_STORE) ? sample_q : '0;
    end

    // Capture sequencer: ADC handshake, channel/frame counters and status flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            addr_q     <= '0;
            pcnt_q     <= '0;
            wcnt_q     <= '0;
            sample_q   <= '0;
            start_q    <= 1'b0;
            chnl_q     <= '0;
            n_convst_q <= 1'b1;
            n_cs_q     <= 1'b1;
            n_rd_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            wr_frame_q <= '0;
`ifdef ADC_TRIG_EN
            armed_q     <= 1'b0;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
`endif
        end else begin
            start_q <= start_i;
            case (state_q)
                S_IDLE: begin
                    if (start_rise) begin
                        ch_q    <= '0;
                        addr_q  <= '0;
                        chnl_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        terr_q  <= 1'b0;
`ifdef ADC_TRIG_EN
                        armed_q     <= 1'b1;
                        have_prev_q <= 1'b0;
`endif
                        state_q <= S_SEL;
                    end
                end
                // chnl is already loaded on entry so it is stable for the
                // whole SEL cycle ahead of the convst edge.
                S_SEL: begin
                    chnl_q     <= 3'(ch_q);
                    n_convst_q <= 1'b0;
                    pcnt_q     <= '0;
                    state_q    <= S_CONV;
                end
                S_CONV: begin
                    if (pcnt_q == PLAST) begin
                        n_convst_q <= 1'b1;
                        wcnt_q     <= '0;
                        state_q    <= S_WAIT;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!adc.n_eoc) begin
                        n_cs_q  <= 1'b0;
                        n_rd_q  <= 1'b0;
                        pcnt_q  <= '0;
                        state_q <= S_READ;
                    end else if (wcnt_q == WLAST) begin
                        terr_q   <= 1'b1;
                        sample_q <= '0;
                        state_q  <= arming ? S_SEL : S_NEXT;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                S_READ: begin
                    if (pcnt_q == PLAST) begin
                        sample_q <= adc.adc_in;
                        n_cs_q   <= 1'b1;
                        n_rd_q   <= 1'b1;
                        state_q  <= arming ? S_ARM : S_STORE;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                S_STORE: begin
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (ch_q != LAST_CH) begin
                        ch_q    <= ch_q + 1'b1;
                        chnl_q  <= 3'(ch_q + 1'b1);
                        state_q <= S_SEL;
                    end else begin
                        ch_q       <= '0;
                        chnl_q     <= '0;
                        wr_frame_q <= addr_q;
                        if (addr_q != LAST_ADDR) begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= S_SEL;
                        end else if (continuous_i) begin
                            addr_q  <= '0;
                            state_q <= S_SEL;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
`ifdef ADC_TRIG_EN
                // Rising crossing of trig_level on ch0 releases storage; the
                // frame after the crossing sample lands at address 0.
                S_ARM: begin
                    if (have_prev_q && (prev_q < trig_level_i) && (sample_q >= trig_level_i)) begin
                        armed_q <= 1'b0;
                    end
                    prev_q      <= sample_q;
                    have_prev_q <= 1'b1;
                    state_q     <= S_SEL;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Sample buffer write port; {ch, addr} equals ch*DEPTH + addr.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[{ch_q, addr_q}] <= mem_wd;
        end
    end

    // Registered read-back; same-cycle write to the location returns old data.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_q <= '0;
        end else if (rd_ch_i <= LAST_CH) begin
            rd_data_q <= mem[{rd_ch_i, rd_addr_i}];
        end
    end

    assign adc.chnl      = chnl_q;
    assign adc.n_convst  = n_convst_q;
    assign adc.n_cs      = n_cs_q;
    assign adc.n_rd      = n_rd_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_err_o = terr_q;
    assign wr_frame_o    = wr_frame_q;
    assign rd_data_o     = rd_data_q;

endmodule

// File: tb/tb_adc_capture_multi.sv
// Directed bench for adc_capture_multi: NCH=4, DEPTH=8, ADC model returns
// 8'h10*channel + per-channel conversion count, with optional withheld EOC.
module tb_adc_capture_multi;

    localparam int unsigned NCH   = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned CHW   = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           continuous;
    logic           busy;
    logic           done;
    logic           timeout_err;
    logic [AW-1:0]  wr_frame;
    logic [CHW-1:0] rd_ch;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  rd_data;
`ifdef ADC_TRIG_EN
    logic [DW-1:0]  trig_level = '0;
`endif

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // ADC model state
    logic          hold_en;
    logic [2:0]    hold_ch;
    logic [7:0]    hold_frame;
    logic [7:0]    cnt [8];
    logic [2:0]    log_ch [128];
    int unsigned   conv_total;
    logic          prev_convst;

    adc_capture_multi_if #(.DW(DW)) adc_if ();

    adc_capture_multi #(
        .NCH(NCH),
        .DW(DW),
        .DEPTH(DEPTH),
        .EOC_TIMEOUT(255),
        .PULSE(2)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .adc           (adc_if),
        .start_i       (start),
        .continuous_i  (continuous),
`ifdef ADC_TRIG_EN
        .trig_level_i  (trig_level),
`endif
        .busy_o        (busy),
        .done_o        (done),
        .timeout_err_o (timeout_err),
        .wr_frame_o    (wr_frame),
        .rd_ch_i       (rd_ch),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data)
    );

    always #5 clk = ~clk;

    // ADC model: latch data on convst falling, assert EOC unless withheld,
    // release EOC once the read strobe is seen.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) cnt[i] <= 8'd0;
            conv_total    <= 0;
            prev_convst   <= 1'b1;
            adc_if.n_eoc  <= 1'b1;
            adc_if.adc_in <= '0;
        end else begin
            prev_convst <= adc_if.n_convst;
            if (!adc_if.n_convst && prev_convst) begin
                adc_if.adc_in <= (8'h10 * {5'd0, adc_if.chnl}) + cnt[adc_if.chnl];
                cnt[adc_if.chnl] <= cnt[adc_if.chnl] + 8'd1;
                if (conv_total < 128) log_ch[conv_total] <= adc_if.chnl;
                conv_total <= conv_total + 1;
                if (!(hold_en && adc_if.chnl == hold_ch && cnt[adc_if.chnl] == hold_frame)) begin
                    adc_if.n_eoc <= 1'b0;
                end
            end
            if (!adc_if.n_rd) adc_if.n_eoc <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input string tag, input int unsigned ch, input int unsigned addr,
                            input logic [7:0] exp);
        rd_ch   = CHW'(ch);
        rd_addr = AW'(addr);
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic wait_done(input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done), 32'(1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        rd_ch      = '0;
        rd_addr    = '0;
        hold_en    = 1'b0;
        hold_ch    = '0;
        hold_frame = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_chnl",     32'(adc_if.chnl),     32'(0));
        check("rst_n_convst", 32'(adc_if.n_convst), 32'(1));
        check("rst_n_cs",     32'(adc_if.n_cs),     32'(1));
        check("rst_n_rd",     32'(adc_if.n_rd),     32'(1));
        check("rst_busy",     32'(busy),            32'(0));
        check("rst_done",     32'(done),            32'(0));
        check("rst_terr",     32'(timeout_err),     32'(0));
        check("rst_wr_frame", 32'(wr_frame),        32'(0));
        check("rst_rd_data",  32'(rd_data),         32'(0));
        reset = 1'b0;

        // Single-shot capture with start held high throughout
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("ss_busy_start", 32'(busy), 32'(1));
        check("ss_done_start", 32'(done), 32'(0));
        wait_done(1000, "ss_done");
        check("ss_busy_end",  32'(busy),        32'(0));
        check("ss_terr",      32'(timeout_err), 32'(0));
        check("ss_wr_frame",  32'(wr_frame),    32'(7));
        check("ss_conv_cnt",  32'(conv_total),  32'(32));
        for (int i = 0; i < 32; i++) begin
            check($sformatf("ss_chnl_%0d", i), 32'(log_ch[i]), 32'(i % 4));
        end
        repeat (40) @(negedge clk);
        check("hold_no_restart_busy", 32'(busy),       32'(0));
        check("hold_no_restart_conv", 32'(conv_total), 32'(32));
        start = 1'b0;

        // Read port: one cycle latency, old value visible until the edge
        rd_ch   = 2'd2;
        rd_addr = 3'd5;
        #1;
        check("rd_before_edge", 32'(rd_data), 32'(8'h00));
        @(negedge clk);
        check("rd_b25", 32'(rd_data), 32'(8'h25));
        rd_check("rd_b00", 0, 0, 8'h00);
        rd_check("rd_b37", 3, 7, 8'h37);
        rd_check("rd_b16", 1, 6, 8'h16);

        // Continuous capture, start pulse while busy, drop continuous after wrap
        do_reset();
        continuous = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'(1));
        n = 0;
        while (wr_frame !== 3'd7 && n < 1000) begin @(negedge clk); n++; end
        check("cont_wf7", 32'(wr_frame), 32'(7));
        n = 0;
        while (wr_frame !== 3'd0 && n < 200) begin @(negedge clk); n++; end
        check("cont_wf0", 32'(wr_frame), 32'(0));
        continuous = 1'b0;
        rd_check("cont_b00_wrapped", 0, 0, 8'h08);
        check("cont_busy_mid", 32'(busy), 32'(1));
        check("cont_done_mid", 32'(done), 32'(0));
        wait_done(1000, "cont_done");
        check("cont_wr_frame", 32'(wr_frame),   32'(7));
        check("cont_conv_cnt", 32'(conv_total), 32'(64));
        for (int i = 0; i < 64; i++) begin
            check($sformatf("cont_chnl_%0d", i), 32'(log_ch[i]), 32'(i % 4));
        end
        rd_check("cont_b00", 0, 0, 8'h08);
        rd_check("cont_b25", 2, 5, 8'h2D);
        rd_check("cont_b37", 3, 7, 8'h3F);

        // EOC timeout on ch1 / frame 3
        do_reset();
        hold_en    = 1'b1;
        hold_ch    = 3'd1;
        hold_frame = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1500, "to_done");
        check("to_terr",     32'(timeout_err), 32'(1));
        check("to_conv_cnt", 32'(conv_total),  32'(32));
        check("to_wr_frame", 32'(wr_frame),    32'(7));
        hold_en = 1'b0;
        rd_check("to_b13", 1, 3, 8'h00);
        rd_check("to_b14", 1, 4, 8'h14);
        rd_check("to_b12", 1, 2, 8'h12);
        rd_check("to_b03", 0, 3, 8'h03);
        rd_check("to_b23", 2, 3, 8'h23);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("to_restart_terr", 32'(timeout_err), 32'(0));
        check("to_restart_busy", 32'(busy),        32'(1));
        check("to_restart_done", 32'(done),        32'(0));

        // Reset while waiting for EOC
        do_reset();
        hold_en    = 1'b1;
        hold_ch    = 3'd1;
        hold_frame = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (conv_total != 2 && n < 100) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        check("mw_pre_busy", 32'(busy),        32'(1));
        check("mw_pre_chnl", 32'(adc_if.chnl), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        check("mw_busy",     32'(busy),            32'(0));
        check("mw_done",     32'(done),            32'(0));
        check("mw_chnl",     32'(adc_if.chnl),     32'(0));
        check("mw_n_convst", 32'(adc_if.n_convst), 32'(1));
        check("mw_n_cs",     32'(adc_if.n_cs),     32'(1));
        check("mw_n_rd",     32'(adc_if.n_rd),     32'(1));
        reset   = 1'b0;
        hold_en = 1'b0;
        repeat (20) @(negedge clk);
        check("mw_idle_conv", 32'(conv_total), 32'(0));
        check("mw_idle_busy", 32'(busy),       32'(0));

        // Reset while the read strobe is low
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (adc_if.n_rd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("mr_rd_low", 32'(adc_if.n_rd), 32'(0));
        reset = 1'b1;
        @(negedge clk);
        check("mr_n_rd", 32'(adc_if.n_rd), 32'(1));
        check("mr_n_cs", 32'(adc_if.n_cs), 32'(1));
        check("mr_busy", 32'(busy),        32'(0));
        reset = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
